// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store.
// Data requests normally win; a starvation counter forces a fetch grant.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_W-1:0]     if_req_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_W-1:0]     if_rsp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_req_we,
    input  logic [DATA_W/8-1:0]   d_req_be,
    input  logic [DATA_W-1:0]     d_req_wdata,
    output logic                  d_rsp_valid,
    output logic [DATA_W-1:0]     d_rsp_data,

    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,

    output logic                  busy
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic       grant_f;
    logic       grant_d;
    logic [3:0] starve_q, starve_d;
    logic       tag_vld_q, tag_vld_d;
    logic       tag_src_f_q, tag_src_f_d;
    logic       tag_we_q, tag_we_d;

    // Grants are gated by reset so nothing reaches the memory while rst is low.
    always_comb begin
        grant_f = 1'b0;
        grant_d = 1'b0;
        if (rst) begin
            if (if_req_valid && d_req_valid) begin
                if (starve_q == StarveMax) begin
                    grant_f = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else if (if_req_valid) begin
                grant_f = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end
        end
    end

    assign if_req_ready = grant_f;
    assign d_req_ready  = grant_d;
    assign mem_en       = grant_f | grant_d;
    assign mem_we       = (grant_d && d_req_we) ? d_req_be : '0;
    assign mem_addr     = grant_f ? if_req_addr : d_req_addr;
    assign mem_wdata    = d_req_wdata;

    always_comb begin
        starve_d    = starve_q;
        tag_vld_d   = grant_f | grant_d;
        tag_src_f_d = grant_f;
        tag_we_d    = grant_d & d_req_we;
        if (!if_req_valid || grant_f) begin
            starve_d = 4'd0;
        end else if (grant_d && (starve_q < StarveMax)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_q    <= 4'd0;
            tag_vld_q   <= 1'b0;
            tag_src_f_q <= 1'b0;
            tag_we_q    <= 1'b0;
        end else begin
            starve_q    <= starve_d;
            tag_vld_q   <= tag_vld_d;
            tag_src_f_q <= tag_src_f_d;
            tag_we_q    <= tag_we_d;
        end
    end

    // Read data arrives one cycle after the grant, aligned with the tag.
    assign if_rsp_valid = tag_vld_q & tag_src_f_q;
    assign d_rsp_valid  = tag_vld_q & ~tag_src_f_q;
    assign if_rsp_data  = if_rsp_valid ? mem_rdata : '0;
    assign d_rsp_data   = (d_rsp_valid && !tag_we_q) ? mem_rdata : '0;
    assign busy         = tag_vld_q;

endmodule
